// File: rtl/nf10_axis_rx_len_stamper.sv
// nf10_axis_rx_len_stamper: store-and-forward 64-bit AXIS stage that stamps byte length and source port into tuser
//   axi_aclk/axi_resetn : clock, asynchronous active-low reset
//   s_axis_*            : MAC receive stream (never backpressured; overflow drops the packet)
//   m_axis_*            : replayed complete packets, tuser = {first-beat tuser[127:32], 8'h00, C_SRC_PORT, len}
//   pkt_stored/dropped  : one-cycle pulses per committed / discarded packet
module nf10_axis_rx_len_stamper #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_LEN_WIDTH = 16,
  parameter int C_SPT_WIDTH = 8,
  parameter logic [C_SPT_WIDTH-1:0] C_SRC_PORT = 8'h01,
  parameter int C_DATA_DEPTH_BITS = 9,
  parameter int C_META_DEPTH_BITS = 4
) (
  input  logic axi_aclk,
  input  logic axi_resetn,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  input  logic s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic m_axis_tlast,
  output logic pkt_stored,
  output logic pkt_dropped
);
  localparam int SB = C_DATA_WIDTH / 8;
  localparam int HW = C_TUSER_WIDTH - 32;
  localparam int DB = C_DATA_DEPTH_BITS;
  localparam int MB = C_META_DEPTH_BITS;
  localparam int EW = 1 + SB + C_DATA_WIDTH;
  localparam int MW = HW + C_LEN_WIDTH;
  typedef enum logic {WR_PKT, WR_DROP} wr_t;
  typedef enum logic {RD_IDLE, RD_SEND} rd_t;
  logic [EW-1:0] mem [2**DB];
  logic [MW-1:0] meta [2**MB];
  logic [DB:0] wr_ptr, wr_start, wr_commit, rd_ptr, ld_ptr;
  logic [MB:0] mw, mr, mr_n, mw_vis;
  logic [C_LEN_WIDTH-1:0] len_acc, len_new;
  logic [C_LEN_WIDTH:0] len_sum;
  logic [HW-1:0] hi_r, hi_cur;
  logic [MW-1:0] meta_head;
  logic in_pkt, acc, fits, meta_full, drop, wr_en, commit, xfer, last_xfer, load, tuser_ld;
  logic unused;
  wr_t wr_st, wr_nxt;
  rd_t rd_st, rd_nxt;
  assign unused = &{1'b0, s_axis_tuser[31:0]};
  always_comb begin
    acc = s_axis_tvalid && s_axis_tready;
    // Occupancy is measured against the handshake-committed read pointer
    fits = !((wr_ptr[DB] != rd_ptr[DB]) && (wr_ptr[DB-1:0] == rd_ptr[DB-1:0]));
    // The packet currently being replayed still holds its meta slot
    meta_full = (mw[MB] != mr[MB]) && (mw[MB-1:0] == mr[MB-1:0]);
    drop = acc && wr_st == WR_PKT && (!fits || (s_axis_tlast && meta_full));
    wr_en = acc && wr_st == WR_PKT && !drop;
    commit = wr_en && s_axis_tlast;
    len_sum = {1'b0, len_acc} + (C_LEN_WIDTH+1)'($countones(s_axis_tstrb));
    len_new = len_sum[C_LEN_WIDTH] ? '1 : len_sum[C_LEN_WIDTH-1:0];
    hi_cur = in_pkt ? hi_r : s_axis_tuser[C_TUSER_WIDTH-1:32];
    wr_nxt = wr_st == WR_PKT ? ((drop && !s_axis_tlast) ? WR_DROP : WR_PKT)
                             : ((acc && s_axis_tlast) ? WR_PKT : WR_DROP);
    xfer = m_axis_tvalid && m_axis_tready;
    last_xfer = xfer && m_axis_tlast;
    mr_n = mr + 1'b1;
    // mw_vis lags mw by a cycle, giving the fixed 3-cycle cut-through latency
    meta_head = meta[rd_st == RD_SEND ? mr_n[MB-1:0] : mr[MB-1:0]];
    tuser_ld = rd_st == RD_IDLE ? mw_vis != mr : last_xfer && mw_vis != mr_n;
    rd_nxt = rd_st == RD_IDLE ? (mw_vis != mr ? RD_SEND : RD_IDLE)
                              : ((last_xfer && mw_vis == mr_n) ? RD_IDLE : RD_SEND);
    // Refill the output register while the packet's tlast word has not been loaded yet
    load = rd_st == RD_SEND && (!m_axis_tvalid || (m_axis_tready && !m_axis_tlast)) && ld_ptr != wr_commit;
  end
  always_ff @(posedge axi_aclk) begin
    if (wr_en) mem[wr_ptr[DB-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    if (commit) meta[mw[MB-1:0]] <= {hi_cur, len_new};
  end
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      s_axis_tready <= 1'b0;
      wr_st <= WR_PKT;
      rd_st <= RD_IDLE;
      pkt_stored <= 1'b0;
      pkt_dropped <= 1'b0;
      wr_ptr <= '0;
      wr_start <= '0;
      wr_commit <= '0;
      rd_ptr <= '0;
      ld_ptr <= '0;
      mw <= '0;
      mr <= '0;
      mw_vis <= '0;
      len_acc <= '0;
      hi_r <= '0;
      in_pkt <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tstrb <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      wr_st <= wr_nxt;
      rd_st <= rd_nxt;
      pkt_stored <= commit;
      pkt_dropped <= drop;
      mw_vis <= mw;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        len_acc <= s_axis_tlast ? '0 : len_new;
        in_pkt <= !s_axis_tlast;
        if (!in_pkt) hi_r <= s_axis_tuser[C_TUSER_WIDTH-1:32];
      end
      if (commit) begin
        wr_commit <= wr_ptr + 1'b1;
        wr_start <= wr_ptr + 1'b1;
        mw <= mw + 1'b1;
      end
      if (drop) begin
        wr_ptr <= wr_start;
        len_acc <= '0;
        in_pkt <= 1'b0;
      end
      if (xfer) rd_ptr <= rd_ptr + 1'b1;
      if (last_xfer) mr <= mr_n;
      if (load) begin
        ld_ptr <= ld_ptr + 1'b1;
        {m_axis_tlast, m_axis_tstrb, m_axis_tdata} <= mem[ld_ptr[DB-1:0]];
        m_axis_tvalid <= 1'b1;
      end else if (xfer) m_axis_tvalid <= 1'b0;
      if (tuser_ld)
        m_axis_tuser <= {meta_head[MW-1:C_LEN_WIDTH], {(32-C_LEN_WIDTH-C_SPT_WIDTH){1'b0}},
                         C_SRC_PORT, meta_head[C_LEN_WIDTH-1:0]};
    end
  end
endmodule

// File: tb/tb_nf10_axis_rx_len_stamper.sv
// tb_nf10_axis_rx_len_stamper: randomized bench with a packet-level store/drop model and a per-beat scoreboard
module tb_nf10_axis_rx_len_stamper;
  typedef struct {logic [63:0] d; logic [7:0] s; logic l; logic [127:0] u;} beat_t;
  logic clk = 1'b0, resetn = 1'b0;
  logic [63:0] s_tdata = '0, m_tdata;
  logic [7:0] s_tstrb = '0, m_tstrb;
  logic [127:0] s_tuser = '0, m_tuser;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic m_tvalid, m_tready = 1'b1, m_tlast, stored, dropped;
  beat_t exp_q[$];
  int n_cmp = 0, n_err = 0, n_st = 0, n_dr = 0, out_beats = 0;
  int mode = 0, mdl_words = 0, mdl_pkts = 0;
  nf10_axis_rx_len_stamper dut (
    .axi_aclk(clk), .axi_resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .pkt_stored(stored), .pkt_dropped(dropped));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask
  // Packet-level view of buffer occupancy while nothing drains: 512 words, 16 packets
  function automatic bit model_store(input int beats);
    if (beats > 512 - mdl_words || mdl_pkts == 16) return 1'b0;
    mdl_words += beats;
    mdl_pkts++;
    return 1'b1;
  endfunction
  initial forever begin
    @(posedge clk); #1;
    m_tready = mode == 0 ? 1'b1 : mode == 1 ? ~m_tready : mode == 2 ? 1'($urandom % 2) : 1'b0;
  end
  always @(negedge clk) begin
    if (stored) n_st++;
    if (dropped) n_dr++;
    if (m_tvalid && m_tready) begin
      out_beats++;
      if (exp_q.size() == 0) check("extra_beat", 1, 0);
      else begin
        beat_t e;
        e = exp_q.pop_front();
        check("tdata", m_tdata, e.d);
        check("tstrb", m_tstrb, e.s);
        check("tlast", m_tlast, e.l);
        check("tuser", m_tuser, e.u);
      end
    end
  end
  task automatic send_pkt(input int nbytes, input bit zb);
    int nb, tot;
    bit st;
    logic [95:0] hi;
    beat_t b;
    nb = (nbytes + 7) / 8;
    tot = nb + int'(zb);
    hi = {$urandom, $urandom, $urandom};
    st = model_store(tot);
    for (int i = 0; i < tot; i++) begin
      int j, rem;
      j = i - int'(zb);
      rem = nbytes - 8 * j;
      b.s = (zb && i == 0) ? 8'h00 : rem >= 8 ? 8'hFF : 8'((1 << rem) - 1);
      b.d = {$urandom, $urandom};
      b.l = i == tot - 1;
      b.u = {hi, 8'h00, 8'h01, 16'(nbytes)};
      if (st) exp_q.push_back(b);
      s_tdata = b.d;
      s_tstrb = b.s;
      s_tlast = b.l;
      s_tuser = i == 0 ? {hi, 32'($urandom)} : {$urandom, $urandom, $urandom, $urandom};
      s_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic drain;
    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_left", exp_q.size(), 0);
    repeat (6) @(posedge clk);
    #1;
    mdl_words = 0;
    mdl_pkts = 0;
  endtask
  initial begin
    int st0, dr0, ob0, lat;
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int st0, dr0, ob0, lat;
    #12;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_stored", stored, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("s_tready_up", s_tready, 1);
    // 60-byte packet and cut-through latency
    st0 = n_st;
    send_pkt(60, 1'b0);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (m_tvalid) lat = k;
    end
    check("latency", lat, 3);
    drain();
    check("t1_stored", n_st - st0, 1);
    // back-to-back 64/1514/1 with tready toggling
    mode = 1;
    st0 = n_st; dr0 = n_dr;
    send_pkt(64, 1'b0);
    send_pkt(1514, 1'b0);
    send_pkt(1, 1'b0);
    drain();
    check("t2_stored", n_st - st0, 3);
    check("t2_dropped", n_dr - dr0, 0);
    // data FIFO overflow: five 1024-byte packets with output stalled
    mode = 3;
    @(posedge clk); #1;
    st0 = n_st; dr0 = n_dr; ob0 = out_beats;
    for (int i = 0; i < 5; i++) send_pkt(1024, 1'b0);
    repeat (4) @(posedge clk);
    check("t3_stored", n_st - st0, 4);
    check("t3_dropped", n_dr - dr0, 1);
    mode = 0;
    drain();
    check("t3_beats", out_beats - ob0, 512);
    // meta FIFO overflow: seventeen one-beat packets
    mode = 3;
    @(posedge clk); #1;
    st0 = n_st; dr0 = n_dr; ob0 = out_beats;
    for (int i = 0; i < 17; i++) send_pkt($urandom_range(1, 8), 1'b0);
    repeat (4) @(posedge clk);
    check("t4_stored", n_st - st0, 16);
    check("t4_dropped", n_dr - dr0, 1);
    mode = 0;
    drain();
    check("t4_beats", out_beats - ob0, 16);
    // reset in the middle of an output packet
    ob0 = out_beats;
    send_pkt(80, 1'b0);
    for (int i = 0; i < 50 && out_beats - ob0 < 2; i++) begin
      @(posedge clk); #1;
    end
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_tdata", m_tdata, 0);
    check("rst_mid_tuser", m_tuser, 0);
    check("rst_mid_tlast", m_tlast, 0);
    check("rst_mid_tready", s_tready, 0);
    exp_q.delete();
    mdl_words = 0;
    mdl_pkts = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    ob0 = out_beats;
    send_pkt(24, 1'b0);
    drain();
    check("t5_beats", out_beats - ob0, 3);
    // oversize packet, then a normal one
    st0 = n_st; dr0 = n_dr;
    send_pkt(4104, 1'b0);
    send_pkt(64, 1'b0);
    drain();
    check("t6_stored", n_st - st0, 1);
    check("t6_dropped", n_dr - dr0, 1);
    // randomized bursts, sized so nothing may drop
    for (int r = 0; r < 6; r++) begin
      int n;
      mode = 2;
      n = $urandom_range(1, 8);
      st0 = n_st; dr0 = n_dr;
      for (int i = 0; i < n; i++) begin
        send_pkt($urandom_range(1, 300), $urandom % 4 == 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      drain();
      check("rnd_stored", n_st - st0, n);
      check("rnd_dropped", n_dr - dr0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nf10_axis_rx_len_stamper.md
Name: nf10_axis_rx_len_stamper

Overview:
- Store-and-forward stage between each 10G MAC receive interface and the 64->256 width converter.
- Buffers each full 64-bit packet and counts its bytes.
- After the packet's last beat, replays the packet with a metadata tuser: byte length, source port, and the upper tuser bits from the packet's first beat.
- Drops packets it cannot hold, so the converter only ever sees complete packets with a valid length.

Parameters:
C_DATA_WIDTH, 64, stream data width (tstrb width = C_DATA_WIDTH/8)
C_TUSER_WIDTH, 128, tuser width
C_LEN_WIDTH, 16, length field at tuser[15:0]
C_SPT_WIDTH, 8, source-port field at tuser[23:16]
C_SRC_PORT, 8'h01, one-hot port code stamped into tuser[23:16]
C_DATA_DEPTH_BITS, 9, data FIFO depth = 2^9 words (4096 bytes)
C_META_DEPTH_BITS, 4, metadata FIFO depth = 16 packets

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
s_axis_tdata  in  64  input data
s_axis_tstrb  in  8  byte enables, contiguous from bit 0
s_axis_tuser  in  128  input sideband; bits [127:32] are sampled on the first beat only
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of packet
m_axis_tdata  out  64  output data
m_axis_tstrb  out  8  output byte enables
m_axis_tuser  out  128  {first-beat tuser[127:32], 8'h00, C_SRC_PORT, len}
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last
pkt_stored  out  1  one-cycle pulse when a packet commits
pkt_dropped  out  1  one-cycle pulse when a packet is discarded

Behaviour:
- Reset, asynchronous, while axi_resetn=0:
  - s_axis_tready, m_axis_tvalid, m_axis_tlast, pkt_stored, pkt_dropped = 0.
  - m_axis_tdata, m_axis_tstrb, m_axis_tuser = 0.
  - All pointers, counters and FSMs clear; any partial or buffered packet is lost.
- s_axis_tready = 1 from the first clock edge after reset deasserts. The stage never backpressures the MAC; overflow is handled by dropping.
- Data FIFO: each entry holds {tlast, tstrb, tdata} (73 bits).
  - Write side uses a speculative pointer wr_ptr and a packet-start pointer wr_start.
  - The read side only sees words up to the committed pointer.
- Input FSM, WR_PKT:
  - Each accepted beat writes one entry and adds popcount(tstrb) to len_acc.
  - len_acc saturates at 2^C_LEN_WIDTH-1.
  - The first beat latches tuser[127:32].
- Commit on the tlast beat when the beat fits and the meta FIFO is not full:
  - Push {hi_tuser, len_acc + popcount(tstrb)} into the meta FIFO.
  - Committed pointer and wr_start <= wr_ptr+1.
  - pkt_stored pulses on the next cycle.
- Drop conditions, checked on any accepted beat:
  - Writing the beat would overrun the unread region (free space 0), or
  - the beat is a tlast beat and the meta FIFO is full.
- On drop:
  - wr_ptr <= wr_start.
  - If the beat is not tlast, go to WR_DROP; a drop on the tlast beat stays in WR_PKT.
  - pkt_dropped pulses once per packet, on the cycle after the drop decision.
- WR_DROP: discard beats until and including tlast, then return to WR_PKT.
- A packet longer than 2^C_DATA_DEPTH_BITS words is always dropped.
- A beat with tstrb=0 is stored and counts 0 bytes.
- Output FSM:
  - RD_IDLE: when the meta FIFO is non-empty, pop the entry into a tuser register and go to RD_SEND.
  - RD_SEND: present FIFO words with m_axis_tvalid=1.
  - A word advances only when m_axis_tvalid && m_axis_tready.
  - m_axis_tuser is held constant for every beat of the packet.
  - After the tlast word transfers: go to RD_SEND for the next packet if meta is non-empty, otherwise RD_IDLE.
- Output AXIS rules:
  - Output data is registered; tdata, tstrb, tlast and tuser are stable while tvalid=1 and tready=0.
  - Back-to-back packets incur at most 1 idle cycle.
- Latency: the first output beat is valid exactly 3 cycles after the input tlast handshake when the stage is otherwise empty.
- Simultaneous commit and output read in the same cycle are both honoured.
- Free space uses the committed read pointer, so words freed this cycle are usable next cycle.
- Pointers wrap modulo 2^C_DATA_DEPTH_BITS; one extra bit distinguishes full from empty.

Test Plan:
1. 60-byte packet: 8 beats, last tstrb=8'h0F, m_axis_tready=1 -> identical 8 output beats, tuser[15:0]=16'd60, tuser[23:16]=8'h01, first beat valid 3 cycles after input tlast, one pkt_stored pulse.
2. Three back-to-back packets (64, 1514 and 1 bytes; the 1-byte packet has tstrb=8'h01), m_axis_tready toggling every cycle -> order preserved, lengths 64/1514/1, tuser held across stalled beats, no pkt_dropped pulses.
3. m_axis_tready=0, five 1024-byte packets (128 beats each) -> four packets stored, fifth packet yields one pkt_dropped pulse; releasing tready then gives exactly four packets out.
4. m_axis_tready=0, seventeen 1-beat packets -> sixteen stored, seventeenth dropped via the meta-full rule; the data FIFO holds exactly 16 words.
5. axi_resetn pulsed low during beat 3 of an output packet -> all outputs 0 immediately; the next packet after release is output correctly with no remnant beats.
6. 4104-byte packet (513 beats) into an empty stage -> dropped, and a following 64-byte packet is output intact with len=64.
